// File: rtl/phase_scheduler_pkg.sv
// Shared constants, FSM encodings and phase-index helper for the phase scheduler.
package phase_scheduler_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MAX_PHASES = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_ABORT  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // Lowest enabled index strictly above k; num when nothing is left. k = -1 finds the first.
    function automatic logic [3:0] next_enabled(input logic [7:0] mask, input int k, input int num);
        next_enabled = 4'(num);
        for (int i = MAX_PHASES - 1; i >= 0; i--) begin
            if (i > k && i < num && mask[i]) begin
                next_enabled = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase run timer: cleared while a phase is being cleared, counts while it runs.
// Latency: expired is combinational from the timer on the cycle the count hits TIMEOUT-1.
// Backpressure: none.
module phase_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] timer;

    always_ff @(posedge clock) begin
        if (!nrst || clear) begin
            timer <= '0;
        end else if (enable) begin
            timer <= timer + 16'd1;
        end
    end

    assign expired = enable && (timer == 16'(TIMEOUT - 1));

endmodule

// File: rtl/phase_scheduler.sv
// Sequences enabled one-shot phases (clear, start, wait done) and owns the shared write port.
// Latency: empty round 2 cycles from run; each phase costs 1 clear cycle plus its run cycles.
// Backpressure: none; run is only sampled in IDLE, writes outside the active RUN phase are dropped.
module phase_scheduler
    import phase_scheduler_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int WORD_WIDTH = phase_scheduler_pkg::WORD_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clock,
    input  logic                             nrst,
    input  logic                             run,
    input  logic [NUM_PHASES-1:0]            phase_en,
    output logic [NUM_PHASES-1:0]            phase_nrst,
    output logic [NUM_PHASES-1:0]            phase_start,
    input  logic [NUM_PHASES-1:0]            phase_done,
    input  logic [NUM_PHASES-1:0]            phase_wr_en,
    input  logic [NUM_PHASES*WORD_WIDTH-1:0] phase_addr,
    input  logic [NUM_PHASES*WORD_WIDTH-1:0] phase_data,
    output logic                             mem_wr_en,
    output logic [WORD_WIDTH-1:0]            mem_addr,
    output logic [WORD_WIDTH-1:0]            mem_data,
    output logic                             busy,
    output logic                             round_done,
    output logic                             timeout_err,
    output logic [2:0]                       err_phase,
    output logic [7:0]                       round_count
);

    localparam int IW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [2:0]            state, state_nx;
    logic [3:0]            idx, idx_nx;
    logic [NUM_PHASES-1:0] mask, mask_nx;
    logic                  aborted, aborted_nx;
    logic                  set_err;
    logic                  expired;
    logic [IW-1:0]         cur, cur_nx;
    logic [7:0]            mask8;

    assign cur    = idx[IW-1:0];
    assign cur_nx = idx_nx[IW-1:0];
    assign mask8  = 8'(mask);

    phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .nrst    (nrst),
        .clear   (state == ST_CLEAR),
        .enable  (state == ST_RUN),
        .expired (expired)
    );

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        mask_nx    = mask;
        aborted_nx = aborted;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    mask_nx    = phase_en;
                    aborted_nx = 1'b0;
                    idx_nx     = next_enabled(8'(phase_en), -1, NUM_PHASES);
                    state_nx   = (phase_en == '0) ? ST_FINISH : ST_CLEAR;
                end
            end
            ST_CLEAR: state_nx = ST_RUN;
            ST_RUN: begin
                // done takes priority over a simultaneous watchdog expiry
                if (phase_done[cur]) begin
                    idx_nx   = next_enabled(mask8, int'(idx), NUM_PHASES);
                    state_nx = (idx_nx == 4'(NUM_PHASES)) ? ST_FINISH : ST_CLEAR;
                end else if (expired) begin
                    set_err    = 1'b1;
                    aborted_nx = 1'b1;
                    state_nx   = ST_ABORT;
                end
            end
            ST_ABORT:  state_nx = ST_FINISH;
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Phase controls are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            mask        <= '0;
            aborted     <= 1'b0;
            phase_nrst  <= '0;
            phase_start <= '0;
            busy        <= 1'b0;
            round_done  <= 1'b0;
            timeout_err <= 1'b0;
            err_phase   <= '0;
            round_count <= '0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            mask        <= mask_nx;
            aborted     <= aborted_nx;
            phase_nrst  <= '1;
            phase_start <= '0;
            if (state_nx == ST_CLEAR || state_nx == ST_ABORT) begin
                phase_nrst[cur_nx] <= 1'b0;
            end
            if (state_nx == ST_RUN) begin
                phase_start[cur_nx] <= 1'b1;
            end
            busy       <= (state_nx != ST_IDLE);
            round_done <= (state == ST_FINISH);
            if (state == ST_FINISH && !aborted) begin
                round_count <= round_count + 8'd1;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
                err_phase   <= 3'(idx);
            end
        end
    end

    assign mem_wr_en = (state == ST_RUN) && phase_wr_en[cur];
    assign mem_addr  = mem_wr_en ? phase_addr[cur*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign mem_data  = mem_wr_en ? phase_data[cur*WORD_WIDTH +: WORD_WIDTH] : '0;

endmodule

// File: tb/tb_phase_scheduler.sv
// Randomized scoreboard bench for phase_scheduler: a round planner predicts every cycle's outputs.
module tb_phase_scheduler;

    localparam int NP = 4;
    localparam int W  = 16;
    localparam int TO = 8;

    localparam int K_IDLE  = 0;
    localparam int K_CLEAR = 1;
    localparam int K_RUN   = 2;
    localparam int K_ABORT = 3;
    localparam int K_FIN   = 4;
    localparam int K_DONE  = 5;

    typedef struct {
        int kind;
        int k;
        int rc;
        bit te;
        int ep;
    } exp_t;

    logic            clock = 1'b0;
    logic            nrst = 1'b0;
    logic            run = 1'b0;
    logic [NP-1:0]   phase_en = '0;
    logic [NP-1:0]   phase_nrst, phase_start;
    logic [NP-1:0]   phase_done = '0;
    logic [NP-1:0]   phase_wr_en = '0;
    logic [NP*W-1:0] phase_addr = '0, phase_data = '0;
    logic            mem_wr_en;
    logic [W-1:0]    mem_addr, mem_data;
    logic            busy, round_done, timeout_err;
    logic [2:0]      err_phase;
    logic [7:0]      round_count;

    int   checks = 0, failures = 0, cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   rst_expect = 1'b1;
    bit   force_wr = 1'b0;
    int   lat[NP];
    int   cnt[NP];
    int   m_rc = 0, m_ep = 0, idle_rc = 0, idle_ep = 0;
    bit   m_te = 1'b0, idle_te = 1'b0;

    phase_scheduler #(.NUM_PHASES(NP), .WORD_WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .nrst        (nrst),
        .run         (run),
        .phase_en    (phase_en),
        .phase_nrst  (phase_nrst),
        .phase_start (phase_start),
        .phase_done  (phase_done),
        .phase_wr_en (phase_wr_en),
        .phase_addr  (phase_addr),
        .phase_data  (phase_data),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .round_done  (round_done),
        .timeout_err (timeout_err),
        .err_phase   (err_phase),
        .round_count (round_count)
    );

    initial forever #5 clock = ~clock;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endfunction

    function automatic void push(input int kind, input int k, input int rc, input bit te, input int ep);
        exp_t e;
        e.kind = kind; e.k = k; e.rc = rc; e.te = te; e.ep = ep;
        exp_q.push_back(e);
    endfunction

    // Per-cycle plan of a round: clear 1 cycle, run lat+1 cycles (done raised lat cycles after
    // start), or TO run cycles plus an abort cycle when the phase would overrun.
    function automatic void plan_round(input logic [NP-1:0] en);
        bit ab = 1'b0;
        bit te = m_te;
        int ep = m_ep;
        for (int k = 0; k < NP; k++) begin
            if (en[k] && !ab) begin
                push(K_CLEAR, k, m_rc, te, ep);
                if (lat[k] >= 1 && lat[k] <= TO - 1) begin
                    repeat (lat[k] + 1) push(K_RUN, k, m_rc, te, ep);
                end else begin
                    repeat (TO) push(K_RUN, k, m_rc, te, ep);
                    te = 1'b1;
                    ep = k;
                    ab = 1'b1;
                    push(K_ABORT, k, m_rc, te, ep);
                end
            end
        end
        push(K_FIN, 0, m_rc, te, ep);
        if (!ab) m_rc = (m_rc + 1) % 256;
        m_te = te;
        m_ep = ep;
        push(K_DONE, 0, m_rc, te, ep);
    endfunction

    // Behavioural sub-blocks: sticky done, cleared by their phase_nrst.
    initial forever begin
        @(negedge clock);
        for (int k = 0; k < NP; k++) begin
            if (!phase_nrst[k]) begin
                cnt[k] = 0;
                phase_done[k] = 1'b0;
            end else if (phase_start[k]) begin
                cnt[k]++;
                if (lat[k] != 0 && cnt[k] == lat[k] + 1) phase_done[k] = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        phase_wr_en = NP'($urandom);
        phase_addr  = {$urandom, $urandom};
        phase_data  = {$urandom, $urandom};
        if (force_wr) begin
            phase_wr_en = 4'b0011;
            phase_addr[W-1:0] = 16'h0002;
            phase_data[W-1:0] = 16'h0001;
        end
    end

    // Monitor: pops one expected cycle per clock and compares every output.
    initial forever begin
        logic [NP-1:0] e_nrst, e_start;
        logic          e_wr;
        logic [W-1:0]  e_addr, e_data;
        bit            have;
        @(posedge clock);
        #1;
        cyc++;
        if (rst_expect) begin
            chk("rst_phase_nrst", phase_nrst, 0);
            chk("rst_phase_start", phase_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_round_done", round_done, 0);
            chk("rst_mem_wr_en", mem_wr_en, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_data", mem_data, 0);
            chk("rst_timeout_err", timeout_err, 0);
            chk("rst_err_phase", err_phase, 0);
            chk("rst_round_count", round_count, 0);
        end else begin
            have = (exp_q.size() > 0);
            if (have) begin
                mon_e = exp_q.pop_front();
            end else begin
                mon_e.kind = K_IDLE; mon_e.k = 0;
                mon_e.rc = idle_rc; mon_e.te = idle_te; mon_e.ep = idle_ep;
            end
            e_nrst = '1; e_start = '0; e_wr = 1'b0; e_addr = '0; e_data = '0;
            if (mon_e.kind == K_CLEAR || mon_e.kind == K_ABORT) e_nrst[mon_e.k] = 1'b0;
            if (mon_e.kind == K_RUN) begin
                e_start[mon_e.k] = 1'b1;
                if (phase_wr_en[mon_e.k]) begin
                    e_wr   = 1'b1;
                    e_addr = phase_addr[mon_e.k*W +: W];
                    e_data = phase_data[mon_e.k*W +: W];
                end
            end
            chk("phase_nrst", phase_nrst, e_nrst);
            chk("phase_start", phase_start, e_start);
            chk("busy", busy, (mon_e.kind >= K_CLEAR && mon_e.kind <= K_FIN));
            chk("round_done", round_done, (mon_e.kind == K_DONE));
            chk("mem_wr_en", mem_wr_en, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data", mem_data, e_data);
            chk("timeout_err", timeout_err, mon_e.te);
            chk("err_phase", err_phase, mon_e.ep);
            chk("round_count", round_count, mon_e.rc);
            if (mon_e.kind == K_DONE) begin
                idle_rc = mon_e.rc; idle_te = mon_e.te; idle_ep = mon_e.ep;
            end
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic apply_reset(input int ncyc);
        run = 1'b0;
        nrst = 1'b0;
        rst_expect = 1'b1;
        exp_q.delete();
        m_rc = 0; m_te = 1'b0; m_ep = 0;
        idle_rc = 0; idle_te = 1'b0; idle_ep = 0;
        repeat (ncyc) @(negedge clock);
        nrst = 1'b1;
        rst_expect = 1'b0;
    endtask

    task automatic issue(input logic [NP-1:0] en);
        run = 1'b1;
        phase_en = en;
        plan_round(en);
        @(negedge clock);
        run = 1'b0;
    endtask

    // run and phase_en are scrambled while busy; the scheduler must ignore them.
    task automatic wait_round();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            run = 1'($urandom);
            phase_en = NP'($urandom);
            @(negedge clock);
            guard++;
        end
        run = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL round_drain cycle=%0d got=%0d pending expected=0", cyc, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int k = 0; k < NP; k++) begin
            lat[k] = 1;
            cnt[k] = 0;
        end
        apply_reset(3);
        @(negedge clock);

        issue(4'b0000); wait_round();

        lat = '{3, 0, 5, 0};
        issue(4'b0101); wait_round();

        force_wr = 1'b1;
        lat[0] = 4;
        issue(4'b0001); wait_round();
        force_wr = 1'b0;

        lat[0] = TO - 1;
        issue(4'b0001); wait_round();

        lat = '{1, 0, 2, 2};
        issue(4'b1110); wait_round();

        lat = '{2, 1, 3, TO};
        issue(4'b1011); wait_round();

        lat[2] = 0;
        issue(4'b0100);
        @(negedge clock);
        @(negedge clock);
        apply_reset(1);
        lat[2] = 2;
        issue(4'b0100); wait_round();

        repeat (30) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            for (int k = 0; k < NP; k++) begin
                lat[k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 9)) : int'($urandom_range(1, 7));
                if ($urandom_range(0, 15) == 0) lat[k] = 0;
            end
            issue(NP'($urandom_range(0, 15)));
            wait_round();
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Per-node round controller for the learning/routing datapath.
- On a run request it steps through up to NUM_PHASES one-shot sub-blocks (action selection, reward update, Q-table update, ...) in index order. For each one it clears, starts and waits for completion.
- While a phase is active, the scheduler owns the node's single memory write port and passes through only the active phase's write.
- A per-phase watchdog aborts a phase that hangs.

Parameters:
- NUM_PHASES, 4, number of sequenced sub-blocks; legal range 1..8.
- WORD_WIDTH, 16, memory address/data width.
- TIMEOUT, 255, maximum cycles a phase may spend in RUN; legal range 2..65535.

Ports:
- clock  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- run  in  1  round request; sampled only in IDLE
- phase_en  in  NUM_PHASES  per-phase enable mask, sampled at round start
- phase_nrst  out  NUM_PHASES  per-phase synchronous active-low clear
- phase_start  out  NUM_PHASES  per-phase start level
- phase_done  in  NUM_PHASES  per-phase done (sticky until that phase is cleared)
- phase_wr_en  in  NUM_PHASES  per-phase write request
- phase_addr  in  NUM_PHASES*WORD_WIDTH  per-phase address; phase k at bits [k*W +: W]
- phase_data  in  NUM_PHASES*WORD_WIDTH  per-phase write data, same packing
- mem_wr_en  out  1  shared memory write enable
- mem_addr  out  WORD_WIDTH  shared memory address
- mem_data  out  WORD_WIDTH  shared memory write data
- busy  out  1  high in any state other than IDLE
- round_done  out  1  one-cycle pulse at end of round, success or abort
- timeout_err  out  1  sticky; set on abort, cleared only by nrst
- err_phase  out  3  index of last timed-out phase
- round_count  out  8  completed successful rounds, wraps 255->0

Behaviour:
- Reset values: phase_nrst all 0 (sub-blocks held in clear), phase_start 0, mem_wr_en 0, mem_addr 0, mem_data 0, busy 0, round_done 0, timeout_err 0, err_phase 0, round_count 0, state IDLE, internal mask 0, index 0.
- First cycle after reset release: phase_nrst goes all 1.
- Reset asserted mid-round: the round is abandoned with no round_done pulse.
- All control outputs are registered (Moore). The mem_* path is combinational from the phase inputs, gated by registered state.
- IDLE:
  - run=1 latches phase_en into the internal mask.
  - Mask nonzero: go to CLEAR for the lowest enabled index k.
  - Mask zero: go to FINISH.
  - run is ignored in all other states.
- CLEAR, 1 cycle:
  - phase_nrst[k]=0, all phase_start 0, timer<=0.
  - Then go to RUN.
- RUN:
  - phase_start[k]=1; timer increments every cycle.
  - If phase_done[k]=1: go to CLEAR of the next enabled index above k, or to FINISH if none remains.
  - Else if timer==TIMEOUT-1: timeout_err<=1, err_phase<=k, go to ABORT.
  - If done and the timeout threshold occur in the same cycle, done wins.
- ABORT, 1 cycle: phase_nrst[k]=0, phase_start 0, then go to FINISH.
- FINISH, 1 cycle:
  - round_done=1.
  - round_count increments only if no abort occurred in this round.
  - Then go to IDLE.
- Latency:
  - Empty mask: run in cycle t gives round_done in cycle t+2.
  - Single phase whose done rises n cycles after its start rises: round_done at t + n + 4.
- Memory port:
  - mem_wr_en = phase_wr_en[k] & (state==RUN).
  - mem_addr and mem_data are phase k's slices when mem_wr_en=1, else 0.
  - Writes from non-active phases, or in CLEAR/ABORT/IDLE/FINISH, are dropped. There is no queuing.
- A phase's done that is still high from a previous round is harmless: CLEAR precedes every RUN.
- Disabled phases never see phase_nrst low or phase_start high during a round.

Decomposition:
- Shared package:
  - WORD_WIDTH (global `WORD_WIDTH, 16).
  - FSM state encodings: IDLE, CLEAR, RUN, ABORT, FINISH.
  - Function returning the next enabled index above k, returning NUM_PHASES if none.
- One sub-module: phase_watchdog, holding the timer, clear/enable inputs and an expired output.
- The memory write mux stays inline.

Test Plan:
- Reset then run=1, phase_en=4'b0000 -> round_done pulses 2 cycles after run; round_count=1; no phase_nrst/phase_start activity.
- phase_en=4'b0101; phase 0 done 3 cycles after start, phase 2 done 5 cycles after start -> order is clear0, start0, clear2, start2; phases 1 and 3 untouched; round_done once; round_count=1.
- Phase 0 active with phase_wr_en[0]=1, addr=16'h2, data=16'h1, and phase_wr_en[1]=1 simultaneously -> mem_wr_en=1, mem_addr=2, mem_data=1; phase 1 write absent on the port.
- TIMEOUT=8, phase 1 never asserts done -> exactly 8 RUN cycles, then ABORT with phase_nrst[1]=0; timeout_err=1, err_phase=1; round_done pulses; round_count unchanged; phases 2-3 not started.
- Done asserted on the threshold cycle (timer==TIMEOUT-1) -> normal advance, timeout_err stays 0.
- nrst dropped during RUN of phase 2 -> next cycle all outputs at reset values, no round_done; a subsequent run completes normally.
